// File: rtl/turn_signal_seq.sv
// Tail-light sequencer: sequential left/right turn and hazard flash on two LED banks.
// Mode is re-decoded every cycle; any change of decoded mode restarts the new sequence at step 0.
module turn_signal_seq #(
   parameter int unsigned N_LEDS      = 3,
   parameter int unsigned STEP_CYCLES = 500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              left_req,
   input  logic              right_req,
   input  logic              hazard_req,
   output logic [N_LEDS-1:0] left_leds,
   output logic [N_LEDS-1:0] right_leds,
   output logic              active
);

   localparam int unsigned CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam int unsigned STEP_W = $clog2(N_LEDS + 1);

   localparam logic [CNT_W-1:0]  CntMax   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [STEP_W-1:0] SeqLast  = STEP_W'(N_LEDS);
   localparam logic [STEP_W-1:0] HazLast  = STEP_W'(1);
   localparam logic [STEP_W-1:0] StepZero = '0;

   typedef enum logic [1:0] {StIdle, StLeft, StRight, StHaz} state_t;

   state_t              state_q, state_d, mode;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [STEP_W-1:0]   step_q, step_d, step_last;
   logic [N_LEDS-1:0]   therm;
   logic [N_LEDS-1:0]   left_d, right_d;
   logic                active_d;

   always_comb begin
      if (hazard_req || (left_req && right_req)) begin
         mode = StHaz;
      end else if (left_req) begin
         mode = StLeft;
      end else if (right_req) begin
         mode = StRight;
      end else begin
         mode = StIdle;
      end
   end

   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      cnt_d     = cnt_q;
      step_last = (state_q == StHaz) ? HazLast : SeqLast;

      if (mode != state_q) begin
         state_d = mode;
         step_d  = '0;
         cnt_d   = '0;
      end else if (state_q != StIdle) begin
         if (cnt_q == CntMax) begin
            cnt_d  = '0;
            step_d = (step_q == step_last) ? StepZero : step_q + STEP_W'(1);
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      // Thermometer fill up to step_d; the extra step past the last LED is all-off.
      for (int i = 0; i < int'(N_LEDS); i++) begin
         therm[i] = (step_d < SeqLast) && (STEP_W'(i) <= step_d);
      end

      left_d   = '0;
      right_d  = '0;
      active_d = 1'b1;
      case (state_d)
         StIdle:  active_d = 1'b0;
         StLeft:  left_d   = therm;
         StRight: right_d  = therm;
         StHaz: begin
            left_d  = (step_d == StepZero) ? {N_LEDS{1'b1}} : '0;
            right_d = (step_d == StepZero) ? {N_LEDS{1'b1}} : '0;
         end
         default: begin
            state_d  = StIdle;
            step_d   = '0;
            cnt_d    = '0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= StIdle;
         step_q     <= '0;
         cnt_q      <= '0;
         left_leds  <= '0;
         right_leds <= '0;
         active     <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         cnt_q      <= cnt_d;
         left_leds  <= left_d;
         right_leds <= right_d;
         active     <= active_d;
      end
   end

endmodule

// File: tb/tb_turn_signal_seq.sv
// Scoreboard bench for turn_signal_seq: two instances (3 LEDs/4 cycles and 8 LEDs/2 cycles)
// share the request inputs; a time-in-mode reference model predicts every post-edge output.
module tb_turn_signal_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       left_req, right_req, hazard_req;
   logic [2:0] a_left, a_right;
   logic       a_active;
   logic [7:0] b_left, b_right;
   logic       b_active;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] al;
      logic [7:0] ar;
      logic [7:0] bl;
      logic [7:0] br;
      logic       act;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   turn_signal_seq #(.N_LEDS(3), .STEP_CYCLES(4)) dut_a (
      .clk        (clk),
      .rst        (rst),
      .left_req   (left_req),
      .right_req  (right_req),
      .hazard_req (hazard_req),
      .left_leds  (a_left),
      .right_leds (a_right),
      .active     (a_active)
   );

   turn_signal_seq #(.N_LEDS(8), .STEP_CYCLES(2)) dut_b (
      .clk        (clk),
      .rst        (rst),
      .left_req   (left_req),
      .right_req  (right_req),
      .hazard_req (hazard_req),
      .left_leds  (b_left),
      .right_leds (b_right),
      .active     (b_active)
   );

   // Modes: 0 idle, 1 left, 2 right, 3 hazard.
   function automatic int decode(input logic l, input logic r, input logic h);
      if (h || (l && r)) return 3;
      if (l) return 1;
      if (r) return 2;
      return 0;
   endfunction

   // Pattern after t cycles spent in a sequential mode: step = t / sc, n+1 steps per period.
   function automatic logic [7:0] seq_pat(input int t, input int n, input int sc);
      int s;
      s = (t / sc) % (n + 1);
      if (s < n) return 8'((1 << (s + 1)) - 1);
      return 8'h00;
   endfunction

   function automatic logic [7:0] haz_pat(input int t, input int n, input int sc);
      if (((t / sc) % 2) == 0) return 8'((1 << n) - 1);
      return 8'h00;
   endfunction

   // Reference model: mode and time-in-mode, advanced on each rising edge.
   int cur_mode = 0;
   int t_in     = 0;

   always @(posedge clk) begin
      int   m;
      exp_t e;
      if (rst) begin
         cur_mode = 0;
         t_in     = 0;
      end else begin
         m = decode(left_req, right_req, hazard_req);
         if (m != cur_mode) begin
            cur_mode = m;
            t_in     = 0;
         end else if (m != 0) begin
            t_in++;
         end
         e.al = 8'h00; e.ar = 8'h00; e.bl = 8'h00; e.br = 8'h00;
         e.act = (cur_mode != 0);
         case (cur_mode)
            1: begin e.al = seq_pat(t_in, 3, 4); e.bl = seq_pat(t_in, 8, 2); end
            2: begin e.ar = seq_pat(t_in, 3, 4); e.br = seq_pat(t_in, 8, 2); end
            3: begin
               e.al = haz_pat(t_in, 3, 4); e.ar = e.al;
               e.bl = haz_pat(t_in, 8, 2); e.br = e.bl;
            end
            default: ;
         endcase
         exp_q.push_back(e);
      end
   end

   // Monitor: outputs are presented every cycle, sampled 1 time unit after the edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         checks++;
         if ({5'b0, a_left} !== e.al || {5'b0, a_right} !== e.ar || b_left !== e.bl ||
             b_right !== e.br || a_active !== e.act || b_active !== e.act) begin
            errors++;
            $display("FAIL outputs @%0t: got a=%b/%b b=%b/%b act=%b/%b want a=%b/%b b=%b/%b act=%b",
                     $time, a_left, a_right, b_left, b_right, a_active, b_active,
                     e.al[2:0], e.ar[2:0], e.bl, e.br, e.act);
         end
      end
   end

   task automatic hold(input logic l, input logic r, input logic h, input int n);
      left_req   = l;
      right_req  = r;
      hazard_req = h;
      repeat (n) @(negedge clk);
   endtask

   task automatic check_zero(input string name);
      checks++;
      if (a_left !== 3'b0 || a_right !== 3'b0 || a_active !== 1'b0 ||
          b_left !== 8'b0 || b_right !== 8'b0 || b_active !== 1'b0) begin
         errors++;
         $display("FAIL %s: got a=%b/%b/%b b=%b/%b/%b want all zero", name,
                  a_left, a_right, a_active, b_left, b_right, b_active);
      end
   endtask

   initial begin
      rst        = 1'b1;
      left_req   = 1'b0;
      right_req  = 1'b0;
      hazard_req = 1'b0;
      #1;
      check_zero("reset_state");
      @(negedge clk);
      rst = 1'b0;

      // Directed sequences from the plan.
      hold(1, 0, 0, 20);
      hold(0, 0, 0, 2);
      hold(0, 1, 0, 20);
      hold(0, 0, 0, 2);
      hold(0, 0, 1, 12);
      hold(1, 0, 1, 10);
      hold(0, 0, 0, 2);
      hold(1, 0, 0, 5);
      hold(1, 1, 0, 3);
      hold(0, 1, 0, 6);
      hold(0, 0, 0, 2);

      // Async reset while the left bank shows 111.
      hold(1, 0, 0, 10);
      #2;
      rst = 1'b1;
      #1;
      check_zero("async_reset");
      @(negedge clk);
      check_zero("held_in_reset");
      rst = 1'b0;
      hold(1, 0, 0, 24);
      hold(0, 0, 0, 3);

      // Randomized request segments.
      repeat (60) begin
         logic [2:0] pick;
         pick = 3'($urandom_range(0, 7));
         hold(pick[0], pick[1], pick[2] & ($urandom_range(0, 2) == 0),
              int'($urandom_range(1, 30)));
      end
      hold(0, 0, 0, 3);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/turn_signal_seq.md
Name: turn_signal_seq

Overview:
- Parametrised tail-light sequencer that drives left and right LED banks.
- Supports sequential left turn, sequential right turn and hazard flash, selected by request inputs with fixed priority.
- Successor to the single-side fixed-width turn FSM: LED count and step period are configurable, and it adds a right channel, a hazard mode and an all-off phase.
- Sits between the debounced switch inputs and the board LED pins; the clock is the slow system tick.

Parameters:
- N_LEDS, 3, LEDs per side; legal range 2..8.
- STEP_CYCLES, 500, clk cycles per sequence step; must be at least 2.
- CNT_W, $clog2(STEP_CYCLES), width of the step counter; derived, not overridden.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  reset: asynchronous, active-high.
- left_req  input  1  left turn request; level-sensitive, synchronous to clk.
- right_req  input  1  right turn request; level-sensitive.
- hazard_req  input  1  hazard request; level-sensitive.
- left_leds  output  N_LEDS  left bank; bit 0 is the innermost LED.
- right_leds  output  N_LEDS  right bank; bit 0 is the innermost LED.
- active  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, step index=0, counter=0.
  - left_leds=0, right_leds=0, active=0.
- Registered outputs: all outputs come from flops updated on the same edge as the state. There is no combinational path from the request inputs to the outputs.
- Mode decode each cycle, in priority order:
  - hazard_req=1, or left_req and right_req both high -> HAZ.
  - else left_req -> LEFT.
  - else right_req -> RIGHT.
  - else IDLE.
- States: IDLE, LEFT, RIGHT, HAZ.
- Step counter:
  - Counts 0..STEP_CYCLES-1 while the FSM is in a non-IDLE state.
  - At terminal count it wraps to 0 and the step index advances.
  - Each step therefore lasts exactly STEP_CYCLES clocks.
- LEFT sequence (N_LEDS+1 steps, repeating):
  - Step k (0..N_LEDS-1) drives left_leds = thermometer code with bits 0..k set.
  - Step N_LEDS is all-off.
  - The step index then wraps to 0.
  - right_leds=0 throughout.
- RIGHT: identical to LEFT on right_leds; left_leds=0 throughout.
- HAZ (2 steps, repeating):
  - Step 0: both banks all-ones.
  - Step 1: both banks all-zero.
  - The step index wraps after step 1.
- Entry:
  - On the edge where the decoded mode differs from the current state, the FSM moves to the new state with step index=0 and counter=0.
  - The step-0 pattern appears on the outputs after that same edge, i.e. one-cycle latency from the request.
- Mode change mid-sequence (e.g. LEFT->HAZ, or LEFT->RIGHT):
  - Immediate restart at step 0 of the new mode.
  - The old pattern is not completed.
- Request drop:
  - Decoded mode IDLE -> state=IDLE on the next edge.
  - Counter, step index and both LED banks are cleared; active=0.
- Simultaneous left_req and right_req is treated as hazard (decode rule above).
- A request that is held steady never re-triggers a restart; only a change in the decoded mode restarts the sequence.
- Reset asserted mid-sequence: outputs go to 0 immediately (asynchronously). After rst is released, the FSM starts from IDLE on the next edge at which a request is decoded.
- Width rules:
  - The counter is CNT_W bits and its terminal-count compare is against STEP_CYCLES-1; the counter never exceeds that value.
  - The step index is wide enough to hold N_LEDS.
- Default branch: any illegal state returns to IDLE with outputs cleared.

Test Plan (N_LEDS=3, STEP_CYCLES=4):
- Reset then left_req=1 held -> left_leds 001 for 4 clk, 011 for 4, 111 for 4, 000 for 4, then 001 again; right_leds=000 throughout; active=1 from the first edge after the request.
- right_req=1 held for 20 clk, then dropped -> right_leds follow the same 001/011/111/000 pattern; on the edge after the drop, right_leds=000 and active=0.
- hazard_req=1 held -> both banks 111 for 4 clk, then 000 for 4, repeating; then raise left_req while hazard is still high -> no change in the pattern (hazard priority).
- left_req=1, and at the 6th clk (left_leds=011) assert right_req=1 -> next edge both banks=111 (HAZ step 0); drop left_req -> next edge right_leds=001, left_leds=000.
- left_req=1 and rst pulsed mid-step while left_leds=111 -> outputs read 000 during rst without a clock edge; after release, left_leds=001 on the first edge.
- Counter boundary with STEP_CYCLES=2, N_LEDS=8 and left_req held -> each thermometer step lasts exactly 2 clk; the full period is 18 clk; left_leds reaches 11111111 and then 00000000.
